// File: rtl/isa_pkg.sv
// Shared ISA constants and issue-sequencer state encoding for the
// instruction issue path.
package isa_pkg;

  localparam int unsigned IW  = 16;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_LOAD = 4'b0001;
  localparam logic [OPW-1:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x W register array with one synchronous write port
// and one registered read port. The array itself is never reset.
module prog_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;
  logic [W-1:0] rd_data_d;

  // Read register holds its value until the next read so the issued word stays stable.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_issue_unit.sv
// Program sequencer: walks the program store from address 0 and presents one
// {pc, op, instruction} bundle per valid/ready handshake to decode.
module instr_issue_unit #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IW    = isa_pkg::IW,
  parameter int unsigned OPW   = isa_pkg::OPW,
  parameter int unsigned WRAP  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [IW-1:0]            load_instr,
  input  logic [OPW-1:0]           load_op,
  input  logic                     start,
  input  logic                     halt_req,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic [OPW-1:0]           op,
  output logic [IW-1:0]            instruction,
  output logic                     busy,
  output logic                     done
);

  import isa_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = OPW + IW;
  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  issue_state_t  state_q, state_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          issue_valid_q, issue_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_en_c;
  logic          rd_en_c;
  logic          handshake_c;
  logic          stop_c;
  logic [WW-1:0] rd_word;

  assign handshake_c = issue_valid_q && issue_ready;
  // A HALT opcode is still issued; the stop only takes effect once it is accepted.
  assign stop_c = (op == OPW'(OP_HALT)) || halt_req || ((pc_q == LAST_PC) && (WRAP == 0));

  prog_mem #(
    .DEPTH (DEPTH),
    .W     (WW)
  ) u_prog_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_c),
    .wr_addr (load_addr),
    .wr_data ({load_op, load_instr}),
    .rd_en   (rd_en_c),
    .rd_addr (fetch_addr_q),
    .rd_data (rd_word)
  );

  // Next-state, fetch address and issued pc.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    wr_en_c      = 1'b0;
    rd_en_c      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        wr_en_c = load_en;
        if (start) begin
          fetch_addr_d = '0;
          state_d      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (halt_req) begin
          state_d = ST_DONE;
        end else begin
          rd_en_c = 1'b1;
          pc_d    = fetch_addr_q;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (handshake_c) begin
          if (stop_c) begin
            state_d = ST_DONE;
          end else begin
            fetch_addr_d = pc_q + AW'(1);
            state_d      = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    issue_valid_d = (state_d == ST_ISSUE);
    busy_d        = (state_d == ST_FETCH) || (state_d == ST_ISSUE);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fetch_addr_q  <= '0;
      pc_q          <= '0;
      issue_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      pc_q          <= pc_d;
      issue_valid_q <= issue_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pc          = pc_q;
  assign op          = rd_word[WW-1:IW];
  assign instruction = rd_word[IW-1:0];

endmodule

// File: tb/tb_instr_issue_unit.sv
// Bench for instr_issue_unit: table-loaded programs, a scoreboard of expected
// issue bundles, and directed sequences for backpressure, wrap, halt and reset.
module tb_instr_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        le_0 = 1'b0, le_w = 1'b0;
  logic [2:0]  load_addr = '0;
  logic [15:0] load_instr = '0;
  logic [3:0]  load_op = '0;
  logic        start_0 = 1'b0, start_w = 1'b0;
  logic        halt_req = 1'b0;
  logic        issue_ready = 1'b0;

  logic        v0, busy0, done0, vw, busyw, donew;
  logic [2:0]  pc0, pcw;
  logic [3:0]  op0, opw;
  logic [15:0] in0, inw;

  typedef struct {
    logic [2:0]  addr;
    logic [3:0]  op;
    logic [15:0] instr;
    logic [2:0]  exp_pc;
    logic [3:0]  exp_op;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t        prog_tbl [8];
  logic [22:0] exp_q [$];
  logic [22:0] got_b, exp_b, hold_b;
  int          n_cmp = 0;
  int          n_err = 0;
  int          seen = 0;
  int          base;
  bit          use_w = 1'b0;
  bit          found;

  always #5 clk = ~clk;

  instr_issue_unit #(.DEPTH(8), .IW(16), .OPW(4), .WRAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(le_0), .load_addr(load_addr),
    .load_instr(load_instr), .load_op(load_op), .start(start_0),
    .halt_req(halt_req), .issue_valid(v0), .issue_ready(issue_ready),
    .pc(pc0), .op(op0), .instruction(in0), .busy(busy0), .done(done0)
  );

  instr_issue_unit #(.DEPTH(8), .IW(16), .OPW(4), .WRAP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .load_en(le_w), .load_addr(load_addr),
    .load_instr(load_instr), .load_op(load_op), .start(start_w),
    .halt_req(halt_req), .issue_valid(vw), .issue_ready(issue_ready),
    .pc(pcw), .op(opw), .instruction(inw), .busy(busyw), .done(donew)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit w, input logic [2:0] a, input logic [3:0] o, input logic [15:0] ins);
    if (w) le_w = 1'b1; else le_0 = 1'b1;
    load_addr  = a;
    load_op    = o;
    load_instr = ins;
    tick();
    le_0 = 1'b0;
    le_w = 1'b0;
  endtask

  task automatic wait_valid(input bit w, input string name);
    int k = 0;
    while (!(w ? vw : v0) && k < 20) begin
      tick();
      k++;
    end
    check(name, 32'(w ? vw : v0), 32'd1);
  endtask

  task automatic wait_done(input bit w, input int budget, input string name);
    int k = 0;
    while (!(w ? donew : done0) && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(w ? donew : done0), 32'd1);
  endtask

  task automatic push(input logic [2:0] p, input logic [3:0] o, input logic [15:0] ins);
    exp_q.push_back({p, o, ins});
  endtask

  // Scoreboard: a handshake happens at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (rst_n && issue_ready && (use_w ? vw : v0)) begin
      got_b = use_w ? {pcw, opw, inw} : {pc0, op0, in0};
      seen++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got %0h expected none", got_b);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_b !== exp_b) begin
          n_err++;
          $display("FAIL issue_bundle: got %0h expected %0h", got_b, exp_b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      prog_tbl[i].addr      = 3'(i);
      prog_tbl[i].op        = 4'((i % 7) + 1);
      prog_tbl[i].instr     = 16'(16'h1111 * i + 16'h00A5);
      prog_tbl[i].exp_pc    = 3'(i);
      prog_tbl[i].exp_op    = 4'((i % 7) + 1);
      prog_tbl[i].exp_instr = 16'(16'h1111 * i + 16'h00A5);
    end

    // Reset values
    #3;
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_bundle", 32'({pc0, op0, in0}), 32'd0);
    check("rst_busy_done", 32'({busy0, done0}), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Three-entry program ending in HALT
    load(1'b0, 3'd0, 4'h1, 16'h0A05);
    load(1'b0, 3'd1, 4'h2, 16'h3120);
    load(1'b0, 3'd2, 4'hF, 16'h0000);
    push(3'd0, 4'h1, 16'h0A05);
    push(3'd1, 4'h2, 16'h3120);
    push(3'd2, 4'hF, 16'h0000);
    base = seen;
    issue_ready = 1'b1;
    start_0 = 1'b1;
    tick();
    start_0 = 1'b0;
    check("t1_fetch_valid", 32'(v0), 32'd0);
    check("t1_fetch_busy", 32'(busy0), 32'd1);
    tick();
    check("t1_first_valid", 32'(v0), 32'd1);
    check("t1_first_pc", 32'(pc0), 32'd0);
    wait_done(1'b0, 20, "t1_done");
    check("t1_issue_count", 32'(seen - base), 32'd3);
    check("t1_busy_low", 32'(busy0), 32'd0);
    check("t1_last_held", 32'({pc0, op0}), 32'({3'd2, 4'hF}));

    // halt_req during FETCH: DONE without updating the issue registers
    halt_req = 1'b1;
    start_0  = 1'b1;
    tick();
    start_0 = 1'b0;
    check("hf_busy", 32'(busy0), 32'd1);
    tick();
    halt_req = 1'b0;
    check("hf_done", 32'({done0, v0}), 32'({1'b1, 1'b0}));
    check("hf_regs_held", 32'({pc0, op0, in0}), 32'({3'd2, 4'hF, 16'h0000}));

    // Full program, backpressure on pc 0, then run to end (WRAP=0)
    for (int i = 0; i < 8; i++) load(1'b0, prog_tbl[i].addr, prog_tbl[i].op, prog_tbl[i].instr);
    for (int i = 0; i < 8; i++) push(prog_tbl[i].exp_pc, prog_tbl[i].exp_op, prog_tbl[i].exp_instr);
    base = seen;
    issue_ready = 1'b0;
    start_0 = 1'b1;
    tick();
    start_0 = 1'b0;
    wait_valid(1'b0, "bp_valid");
    hold_b = {pc0, op0, in0};
    check("bp_pc0", 32'(pc0), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(v0), 32'd1);
      check("bp_hold_bundle", 32'({pc0, op0, in0}), 32'(hold_b));
    end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("bp_valid_drop", 32'(v0), 32'd0);
    check("bp_one_accept", 32'(seen - base), 32'd1);
    tick();
    check("bp_next_valid", 32'({v0, pc0}), 32'({1'b1, 3'd1}));
    issue_ready = 1'b1;
    wait_done(1'b0, 40, "full_done");
    check("full_count", 32'(seen - base), 32'd8);
    check("full_last_pc", 32'(pc0), 32'd7);

    // Load with start from DONE hits addr 0; load during ISSUE is ignored
    issue_ready = 1'b0;
    push(3'd0, 4'h3, 16'hBEEF);
    for (int i = 1; i < 8; i++) push(prog_tbl[i].exp_pc, prog_tbl[i].exp_op, prog_tbl[i].exp_instr);
    base = seen;
    le_0 = 1'b1;
    load_addr = 3'd0;
    load_op = 4'h3;
    load_instr = 16'hBEEF;
    start_0 = 1'b1;
    tick();
    le_0 = 1'b0;
    start_0 = 1'b0;
    wait_valid(1'b0, "ls_valid");
    check("ls_new_word", 32'({pc0, op0, in0}), 32'({3'd0, 4'h3, 16'hBEEF}));
    load(1'b0, 3'd3, 4'hC, 16'hDEAD);
    issue_ready = 1'b1;
    wait_done(1'b0, 40, "ls_done");
    check("ls_count", 32'(seen - base), 32'd8);

    // WRAP=1 instance: pc 7 -> 0, halt_req on second pc 1
    use_w = 1'b1;
    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(1'b1, prog_tbl[i].addr, prog_tbl[i].op, prog_tbl[i].instr);
    for (int i = 0; i < 8; i++) push(prog_tbl[i].exp_pc, prog_tbl[i].exp_op, prog_tbl[i].exp_instr);
    push(prog_tbl[0].exp_pc, prog_tbl[0].exp_op, prog_tbl[0].exp_instr);
    push(prog_tbl[1].exp_pc, prog_tbl[1].exp_op, prog_tbl[1].exp_instr);
    base = seen;
    issue_ready = 1'b1;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (vw && pcw == 3'd1 && (seen - base) == 9) found = 1'b1;
    end
    check("wrap_reach_pc1", 32'(found), 32'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("wrap_done", 32'({donew, busyw}), 32'({1'b1, 1'b0}));
    check("wrap_count", 32'(seen - base), 32'd10);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    use_w = 1'b0;

    // Reset asserted mid-ISSUE
    issue_ready = 1'b0;
    start_0 = 1'b1;
    tick();
    start_0 = 1'b0;
    wait_valid(1'b0, "rm_valid");
    #2 rst_n = 1'b0;
    #1;
    check("rm_valid_drop", 32'(v0), 32'd0);
    check("rm_bundle_zero", 32'({pc0, op0, in0}), 32'd0);
    check("rm_flags_zero", 32'({busy0, done0, donew}), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rm_idle", 32'({v0, busy0, done0}), 32'd0);
    end
    start_0 = 1'b1;
    tick();
    start_0 = 1'b0;
    tick();
    check("rm_restart", 32'({v0, pc0}), 32'({1'b1, 3'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
